// File: rtl/rpn_pkg.sv
// rpn_pkg: constants shared by the RPN tokenizer and the downstream evaluator.
//   DW_DEF      default token / accumulator width
//   ASC_*       ASCII codes for the operators, separators and the digit range
//   tok_state_t tokenizer FSM state encoding
//   is_digit / is_op / is_sep  character class helpers
package rpn_pkg;

    localparam int DW_DEF = 32;

    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_MUL   = 8'h2A;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_NUM      = 2'd1,
        ST_EMIT_NUM = 2'd2,
        ST_EMIT_OP  = 2'd3
    } tok_state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASC_0) && (c <= ASC_9);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == ASC_PLUS) || (c == ASC_MINUS) || (c == ASC_MUL);
    endfunction

    function automatic logic is_sep(input logic [7:0] c);
        return (c == ASC_SP) || (c == ASC_CR) || (c == ASC_LF) || (c == ASC_EQ);
    endfunction

endpackage

// File: rtl/rpn_tokenizer_dec_acc.sv
// dec_acc: combinational decimal accumulate step, acc*10 + digit.
//   acc   in  DW  current accumulator
//   digit in  4   decimal digit value 0..9
//   sum   out DW  new accumulator, saturated to all ones on overflow
//   ovf   out 1   result exceeded 2^DW-1
module dec_acc
    import rpn_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] acc,
    input  logic [3:0]    digit,
    output logic [DW-1:0] sum,
    output logic          ovf
);

    // acc*10 < 16*2^DW, so four extra bits hold the exact result.
    logic [DW+3:0] wide;

    always_comb begin
        wide = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{DW{1'b0}}, digit};
        ovf  = |wide[DW+3:DW];
        sum  = ovf ? {DW{1'b1}} : wide[DW-1:0];
    end

endmodule

// File: rtl/rpn_tokenizer.sv
// rpn_tokenizer: turns an ASCII character stream into operand/operator tokens
// for the RPN stack push port.
//   CLK, RST          clock, asynchronous active-high reset
//   RX_STB/DAT/ACK    character input handshake
//   PUSH_STB/DAT/ACK  token output handshake (registered data)
//   OVF               sticky: an operand saturated
//   ERR               sticky: illegal character or operand equal to an operator code
module rpn_tokenizer
    import rpn_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RX_STB,
    input  logic [7:0]    RX_DAT,
    output logic          RX_ACK,
    output logic          PUSH_STB,
    output logic [DW-1:0] PUSH_DAT,
    input  logic          PUSH_ACK,
    output logic          OVF,
    output logic          ERR
);

    tok_state_t    state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [7:0]    op_q, op_d;
    logic          op_pend_q, op_pend_d;
    logic          push_stb_q, push_stb_d;
    logic [DW-1:0] push_dat_q, push_dat_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic [DW-1:0] acc_base;
    logic [DW-1:0] acc_next;
    logic          acc_ovf;
    logic          rx_fire;
    logic          push_fire;
    logic          collide;

    // A fresh operand starts from zero regardless of what acc holds.
    assign acc_base = (state_q == ST_IDLE) ? '0 : acc_q;

    dec_acc #(.DW(DW)) u_dec_acc (
        .acc   (acc_base),
        .digit (RX_DAT[3:0]),
        .sum   (acc_next),
        .ovf   (acc_ovf)
    );

    assign RX_ACK    = (state_q == ST_IDLE) || (state_q == ST_NUM);
    assign rx_fire   = RX_STB && RX_ACK;
    assign push_fire = push_stb_q && PUSH_ACK;

    // An operand that equals an operator code would be misread by the stack.
    assign collide = (acc_q == {{(DW-8){1'b0}}, ASC_PLUS})  ||
                     (acc_q == {{(DW-8){1'b0}}, ASC_MINUS}) ||
                     (acc_q == {{(DW-8){1'b0}}, ASC_MUL});

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        op_d       = op_q;
        op_pend_d  = op_pend_q;
        push_stb_d = push_stb_q;
        push_dat_d = push_dat_q;
        ovf_d      = ovf_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE, ST_NUM: begin
                if (rx_fire) begin
                    if (is_digit(RX_DAT)) begin
                        acc_d   = acc_next;
                        ovf_d   = ovf_q | acc_ovf;
                        state_d = ST_NUM;
                    end else if (is_op(RX_DAT)) begin
                        op_d       = RX_DAT;
                        op_pend_d  = 1'b1;
                        push_stb_d = 1'b1;
                        if (state_q == ST_NUM) begin
                            state_d    = ST_EMIT_NUM;
                            push_dat_d = acc_q;
                            err_d      = err_q | collide;
                        end else begin
                            state_d    = ST_EMIT_OP;
                            push_dat_d = {{(DW-8){1'b0}}, RX_DAT};
                        end
                    end else if (is_sep(RX_DAT)) begin
                        if (state_q == ST_NUM) begin
                            state_d    = ST_EMIT_NUM;
                            push_stb_d = 1'b1;
                            push_dat_d = acc_q;
                            err_d      = err_q | collide;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EMIT_NUM: begin
                if (push_fire) begin
                    acc_d = '0;
                    if (op_pend_q) begin
                        state_d    = ST_EMIT_OP;
                        push_dat_d = {{(DW-8){1'b0}}, op_q};
                    end else begin
                        state_d    = ST_IDLE;
                        push_stb_d = 1'b0;
                    end
                end
            end
            ST_EMIT_OP: begin
                if (push_fire) begin
                    state_d    = ST_IDLE;
                    op_pend_d  = 1'b0;
                    push_stb_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            op_q       <= '0;
            op_pend_q  <= 1'b0;
            push_stb_q <= 1'b0;
            push_dat_q <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            op_pend_q  <= op_pend_d;
            push_stb_q <= push_stb_d;
            push_dat_q <= push_dat_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    assign PUSH_STB = push_stb_q;
    assign PUSH_DAT = push_dat_q;
    assign OVF      = ovf_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_rpn_tokenizer.sv
module tb_rpn_tokenizer;

    logic        CLK;
    logic        RST;
    logic        RX_STB;
    logic [7:0]  RX_DAT;
    logic        RX_ACK;
    logic        PUSH_STB;
    logic [31:0] PUSH_DAT;
    logic        PUSH_ACK;
    logic        OVF;
    logic        ERR;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] exp_q[$];

    rpn_tokenizer #(.DW(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_STB   (RX_STB),
        .RX_DAT   (RX_DAT),
        .RX_ACK   (RX_ACK),
        .PUSH_STB (PUSH_STB),
        .PUSH_DAT (PUSH_DAT),
        .PUSH_ACK (PUSH_ACK),
        .OVF      (OVF),
        .ERR      (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    // Scoreboard monitor: a transfer happens at the next rising edge when
    // PUSH_STB and PUSH_ACK are both high at the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && PUSH_STB && PUSH_ACK) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_token", PUSH_DAT, 32'hDEAD_BEEF);
                end else begin
                    check("token", PUSH_DAT, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        RX_STB = 1'b1;
        RX_DAT = c;
        forever begin
            @(negedge CLK);
            if (RX_ACK) break;
            n++;
            if (n > 200) begin
                check("rx_ack_timeout", {24'b0, c}, 32'hFFFF_FFFF);
                RX_STB = 1'b0;
                return;
            end
        end
        @(posedge CLK);
        #1;
        RX_STB = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        idle_cycles(2);
        RST = 1'b0;
    endtask

    task automatic wait_push_stb(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge CLK);
            if (PUSH_STB) break;
            n++;
            if (n > 100) begin
                check(name, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    int bubbles;
    int bad_hold;

    initial begin
        RST      = 1'b1;
        RX_STB   = 1'b0;
        RX_DAT   = 8'h00;
        PUSH_ACK = 1'b0;
        #12;
        check("rst_rx_ack",   {31'b0, RX_ACK},   32'd1);
        check("rst_push_stb", {31'b0, PUSH_STB}, 32'd0);
        check("rst_push_dat", PUSH_DAT,          32'd0);
        check("rst_ovf",      {31'b0, OVF},      32'd0);
        check("rst_err",      {31'b0, ERR},      32'd0);
        idle_cycles(1);
        RST = 1'b0;

        // Two operands and an operator, stack always ready
        PUSH_ACK = 1'b1;
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd34);
        exp_q.push_back(32'h2B);
        send_str("12 34 +\r");
        idle_cycles(5);
        check("basic_ovf", {31'b0, OVF}, 32'd0);
        check("basic_err", {31'b0, ERR}, 32'd0);

        // Operand followed directly by operator: two bubbles on RX_ACK
        exp_q.push_back(32'd7);
        exp_q.push_back(32'h2A);
        send("7");
        send("*");
        bubbles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (RX_ACK) break;
            bubbles++;
        end
        check("op_bubbles", bubbles, 32'd2);
        idle_cycles(3);

        // Saturation
        exp_q.push_back(32'hFFFF_FFFF);
        send_str("4294967296 ");
        idle_cycles(4);
        check("ovf_set", {31'b0, OVF}, 32'd1);
        do_reset();
        check("ovf_cleared_by_rst", {31'b0, OVF}, 32'd0);
        exp_q.push_back(32'hFFFF_FFFF);
        send_str("4294967295 ");
        idle_cycles(4);
        check("max_no_ovf", {31'b0, OVF}, 32'd0);

        // Backpressure: stack full for 20 cycles after the first token appears
        PUSH_ACK = 1'b0;
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd9);
        exp_q.push_back(32'h2B);
        bad_hold = 0;
        fork
            send_str("5 9+");
            begin
                wait_push_stb("stall_stb_timeout");
                for (int i = 0; i < 20; i++) begin
                    if (!PUSH_STB || PUSH_DAT != 32'd5 || RX_ACK) bad_hold++;
                    @(negedge CLK);
                end
                check("stall_hold", bad_hold, 32'd0);
                @(posedge CLK);
                #1;
                PUSH_ACK = 1'b1;
            end
        join
        idle_cycles(6);
        check("stall_drained", exp_q.size(), 32'd0);

        // Illegal character is dropped
        exp_q.push_back(32'd34);
        send_str("3x4 ");
        idle_cycles(3);
        check("illegal_err", {31'b0, ERR}, 32'd1);
        do_reset();
        check("err_cleared_by_rst", {31'b0, ERR}, 32'd0);

        // Operand colliding with the '+' code
        exp_q.push_back(32'd43);
        send_str("43 ");
        idle_cycles(3);
        check("collision_err", {31'b0, ERR}, 32'd1);

        // Reset while a token is pending
        PUSH_ACK = 1'b0;
        send_str("88 ");
        wait_push_stb("emit88_timeout");
        check("emit88_dat", PUSH_DAT, 32'd88);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("async_rst_stb", {31'b0, PUSH_STB}, 32'd0);
        check("async_rst_err", {31'b0, ERR},      32'd0);
        check("async_rst_ovf", {31'b0, OVF},      32'd0);
        #2;
        RST = 1'b0;
        PUSH_ACK = 1'b1;
        exp_q.push_back(32'd1);
        send_str("1 ");
        idle_cycles(5);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rpn_tokenizer.md
# rpn_tokenizer

Converts an ASCII character stream (UART receive side) into 32-bit tokens for the RPN calculator stack: decimal digit runs become unsigned binary operands, and `+`, `-`, `*` become operator tokens. It sits directly upstream of the stack and drives its push port (PUSH_STB / PUSH_DAT / PUSH_ACK). Backpressure from a full stack stalls character intake.

## Interface
- DW, 32, token and accumulator width.
- CLK  in  1  clock. Reset RST is asynchronous, active-high; clock is CLK.
- RST  in  1  asynchronous active-high reset.
- RX_STB  in  1  character valid.
- RX_DAT  in  8  ASCII character.
- RX_ACK  out  1  character accepted when RX_STB && RX_ACK at the CLK rising edge.
- PUSH_STB  out  1  token valid, held until accepted.
- PUSH_DAT  out  DW  token value, stable while PUSH_STB is high.
- PUSH_ACK  in  1  stack accepts the token; transfer occurs on PUSH_STB && PUSH_ACK at the edge.
- OVF  out  1  sticky flag: an operand exceeded 2^DW-1.
- ERR  out  1  sticky flag: an illegal character was received, or an operand collides with an operator code.

## Operation
- Character classes:
  - digit: 0x30–0x39.
  - operator: 0x2B `+`, 0x2D `-`, 0x2A `*`.
  - separator: 0x20, 0x0D, 0x0A, 0x3D `=`.
  - anything else is illegal.
- States:
  - IDLE: no pending operand.
  - NUM: accumulating an operand.
  - EMIT_NUM: PUSH_STB high with the accumulator value.
  - EMIT_OP: PUSH_STB high with the operator value.
- RX_ACK = (state==IDLE || state==NUM). No character is accepted in either EMIT state.
- Digit accepted:
  - acc <= acc*10 + (c-0x30), computed DW+4 bits wide.
  - If the result exceeds 2^DW-1: acc saturates to all ones and OVF sets.
  - IDLE→NUM; in IDLE, acc starts from 0.
- Operator accepted:
  - The operator is latched in op_r.
  - From NUM → EMIT_NUM, then EMIT_OP.
  - From IDLE → EMIT_OP directly.
- Separator accepted: NUM→EMIT_NUM, then IDLE. In IDLE a separator is ignored; repeated separators emit nothing.
- Illegal character accepted: dropped, ERR sets, state and acc unchanged.
- Token encoding:
  - Operand: acc, unsigned.
  - Operator: {(DW-8)'b0, ASCII}, i.e. 0x2B / 0x2D / 0x2A, exactly the codes the stack compares against.
- Operand collision: an emitted operand equal to 0x2A, 0x2B or 0x2D sets ERR. The operand is still pushed unchanged.
- EMIT_NUM exit on PUSH_ACK:
  - to EMIT_OP if an operator is latched (op_pend=1);
  - otherwise to IDLE.
  - acc clears either way.
- EMIT_OP exit on PUSH_ACK: to IDLE, op_pend clears.
- OVF and ERR are cleared only by RST.

## Timing
- Reset values:
  - state IDLE, acc 0, op_pend 0.
  - PUSH_STB 0, PUSH_DAT 0, OVF 0, ERR 0.
  - RX_ACK 1: combinational from state; no capture while RST is high.
- Digits: one character per cycle, zero stall.
- Separator ending an operand:
  - PUSH_STB rises the cycle after acceptance.
  - With PUSH_ACK already high, the transfer completes that cycle and RX_ACK returns the next cycle, i.e. 1 bubble.
- Operator after an operand:
  - Operand push first, then the operator push on the cycle following its ACK.
  - Minimum 2 bubbles.
- PUSH_ACK low (stack full): PUSH_STB/PUSH_DAT hold indefinitely and RX_ACK stays low.
- PUSH_ACK is sampled only while PUSH_STB is high; it is ignored otherwise.
- RST mid-EMIT: the pending token is discarded and PUSH_STB drops asynchronously.
- Accumulator arithmetic is registered. PUSH_DAT is a registered output, no combinational path from RX_DAT.

## Structure
- Package rpn_pkg holds:
  - ASCII constants (ASC_PLUS, ASC_MINUS, ASC_MUL, ASC_SP, ASC_CR, ASC_LF, ASC_EQ, ASC_0, ASC_9);
  - the tokenizer state enum;
  - the DW default.
  - The future evaluator stage shares these constants.
- One sub-module, dec_acc: combinational acc*10+digit with saturation and overflow output (shift-add, DW+4 internal width).
- Top level: the FSM, op_r/op_pend registers, flags, and the push-port output register.

## Test plan
- "12 34 +\r", PUSH_ACK tied 1 → pushes 12, 34, 0x2B in order; OVF=0, ERR=0.
- "7*" → pushes 7 then 0x2A; no token emitted in between, RX_ACK low for 2 cycles.
- "4294967296 " → pushes 0xFFFFFFFF; OVF=1. "4294967295 " after reset → pushes 0xFFFFFFFF with OVF=0.
- "5 9+" with PUSH_ACK held 0 for 20 cycles after the first push → PUSH_STB/PUSH_DAT=5 held stable, RX_ACK=0, no byte lost; on release the tokens 5, 9, 0x2B arrive.
- "3x4 " → x is dropped, ERR=1, and 34 is pushed; "43 " → pushes 43 and sets ERR (collision).
- RST pulse asserted while in EMIT_NUM with value 88 → PUSH_STB=0 immediately, all flags 0; next input "1 " pushes 1.
